// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: control-transfer opcodes and sequencer state encoding
package pc_seq_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  typedef enum logic [1:0] {BOOT, RUN, JR_WAIT, FLUSH} state_t;
endpackage

// File: rtl/xfer_decode.sv
// xfer_decode: classifies the decode-stage instruction into control-transfer kinds
module xfer_decode
  import pc_seq_pkg::*;
(
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_jump,
  output logic       is_link,
  output logic       is_jreg,
  output logic       is_branch,
  output logic       br_ne
);
  always_comb begin
    is_jreg   = instr_valid && opcode == OP_RTYPE && (funct == FN_JR || funct == FN_JALR);
    is_jump   = instr_valid && (opcode == OP_J || opcode == OP_JAL);
    is_link   = (is_jump && opcode == OP_JAL) || (is_jreg && funct == FN_JALR);
    is_branch = instr_valid && (opcode == OP_BEQ || opcode == OP_BNE);
    br_ne     = opcode == OP_BNE;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, control-transfer redirect, flush and jr hazard stall
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [ADDR_W-1:0] dec_pc,
  input  logic [15:0]       imm,
  input  logic [25:0]       jidx,
  input  logic [ADDR_W-1:0] rs_value,
  input  logic              rs_hazard,
  input  logic              rs_eq_rt,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              stall,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              addr_err,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_t            state;
  logic              is_jump, is_link, is_jreg, is_branch, br_ne, active, taken;
  logic [ADDR_W-1:0] seq_pc, target;
  xfer_decode u_dec (
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .funct      (funct),
    .is_jump    (is_jump),
    .is_link    (is_link),
    .is_jreg    (is_jreg),
    .is_branch  (is_branch),
    .br_ne      (br_ne)
  );
  always_comb begin
    active   = state == RUN || state == JR_WAIT;
    seq_pc   = dec_pc + ADDR_W'(4);
    stall    = active && is_jreg && rs_hazard;
    taken    = active && ((is_jreg && !rs_hazard) ||
               (state == RUN && (is_jump || (is_branch && (rs_eq_rt ^ br_ne)))));
    target   = is_jreg ? {rs_value[ADDR_W-1:2], 2'b00} :
               is_jump ? {seq_pc[ADDR_W-1:28], jidx, 2'b00} :
               seq_pc + {{(ADDR_W-18){imm[15]}}, imm, 2'b00};
    pc_valid = state != BOOT;
    flush    = state == FLUSH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      link_we   <= 1'b0;
      link_addr <= '0;
      addr_err  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= (state == BOOT || state == FLUSH) ? RUN : taken ? FLUSH : stall ? JR_WAIT : RUN;
      pc        <= taken ? target :
                   ((state == RUN || state == FLUSH) && !stall && imem_ready) ? pc + ADDR_W'(4) : pc;
      link_we   <= taken && is_link;
      link_addr <= (taken && is_link) ? seq_pc : link_addr;
      addr_err  <= addr_err || (taken && is_jreg && rs_value[1:0] != 2'b00);
      stall_cnt <= (stall && !(&stall_cnt)) ? stall_cnt + CNT_W'(1) : stall_cnt;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenario tests for the PC sequencer
module tb_pc_sequencer;
  import pc_seq_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, instr_valid = 1'b0, rs_hazard = 1'b0, rs_eq_rt = 1'b0, imem_ready = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic [31:0] dec_pc = '0, rs_value = '0;
  logic [15:0] imm = '0;
  logic [25:0] jidx = '0;
  logic [31:0] pc, link_addr;
  logic        pc_valid, stall, flush, link_we, addr_err;
  logic [7:0]  stall_cnt;
  int          checks = 0, errors = 0;
  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .funct      (funct),
    .dec_pc     (dec_pc),
    .imm        (imm),
    .jidx       (jidx),
    .rs_value   (rs_value),
    .rs_hazard  (rs_hazard),
    .rs_eq_rt   (rs_eq_rt),
    .imem_ready (imem_ready),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .stall      (stall),
    .flush      (flush),
    .link_we    (link_we),
    .link_addr  (link_addr),
    .addr_err   (addr_err),
    .stall_cnt  (stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] dpc);
    instr_valid = 1'b1;
    opcode = op;
    funct = fn;
    dec_pc = dpc;
  endtask
  task automatic settle;
    instr_valid = 1'b0;
    imem_ready = 1'b0;
    tick();
  endtask
  task automatic test_reset;
    imem_ready = 1'b1;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h expected %h", pc, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_pc_valid got %b expected 0", pc_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b expected 0", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b expected 0", flush); end
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL rst_link_we got %b expected 0", link_we); end
    checks++; if (link_addr !== 32'h0) begin errors++; $display("FAIL rst_link_addr got %h expected 0", link_addr); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got %b expected 0", addr_err); end
    checks++; if (stall_cnt !== 8'h0) begin errors++; $display("FAIL rst_stall_cnt got %0d expected 0", stall_cnt); end
    repeat (2) tick();
    rst_n = 1'b1;
  endtask
  task automatic test_boot;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_pc_valid got %b expected 0", pc_valid); end
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc0 got %h expected %h", pc, 32'h0); end
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL run_pc_valid got %b expected 1", pc_valid); end
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL boot_pc4 got %h expected %h", pc, 32'h4); end
    tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL boot_pc8 got %h expected %h", pc, 32'h8); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL boot_flush got %b expected 0", flush); end
  endtask
  task automatic test_branch;
    instr(OP_BEQ, 6'h0, 32'h100);
    imm = 16'hFFFE;
    rs_eq_rt = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL beq_stall got %b expected 0", stall); end
    tick();
    checks++; if (pc !== 32'h0FC) begin errors++; $display("FAIL beq_taken_pc got %h expected %h", pc, 32'h0FC); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush got %b expected 1", flush); end
    settle();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_flush_once got %b expected 0", flush); end
    instr(OP_BEQ, 6'h0, 32'h100);
    rs_eq_rt = 1'b0;
    imem_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL beq_not_taken_pc got %h expected %h", pc, 32'h100); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_not_taken_flush got %b expected 0", flush); end
    instr(OP_BNE, 6'h0, 32'h200);
    imm = 16'h0003;
    tick();
    checks++; if (pc !== 32'h210) begin errors++; $display("FAIL bne_taken_pc got %h expected %h", pc, 32'h210); end
    settle();
    instr(OP_BEQ, 6'h0, 32'h0);
    imm = 16'hFFFE;
    rs_eq_rt = 1'b1;
    imem_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_wrap_pc got %h expected %h", pc, 32'hFFFF_FFFC); end
    settle();
  endtask
  task automatic test_jal;
    imem_ready = 1'b1;
    instr(OP_JAL, 6'h0, 32'h0040_0010);
    jidx = 26'h0000100;
    tick();
    checks++; if (pc !== 32'h400) begin errors++; $display("FAIL jal_pc got %h expected %h", pc, 32'h400); end
    checks++; if (link_we !== 1'b1) begin errors++; $display("FAIL jal_link_we got %b expected 1", link_we); end
    checks++; if (link_addr !== 32'h0040_0014) begin errors++; $display("FAIL jal_link_addr got %h expected %h", link_addr, 32'h0040_0014); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jal_flush got %b expected 1", flush); end
    settle();
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL jal_link_pulse got %b expected 0", link_we); end
    checks++; if (pc !== 32'h400) begin errors++; $display("FAIL jal_pc_hold got %h expected %h", pc, 32'h400); end
  endtask
  task automatic test_jr_stall;
    imem_ready = 1'b1;
    instr(OP_RTYPE, FN_JR, 32'h600);
    rs_hazard = 1'b1;
    rs_value = 32'h1234;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL jr_stall0 got %b expected 1", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jr_stall_flush got %b expected 0", flush); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL jr_stall1 got %b expected 1", stall); end
    checks++; if (pc !== 32'h400) begin errors++; $display("FAIL jr_pc_hold got %h expected %h", pc, 32'h400); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL jr_stall2 got %b expected 1", stall); end
    tick();
    rs_hazard = 1'b0;
    rs_value = 32'h2000;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jr_release_stall got %b expected 0", stall); end
    checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL jr_stall_cnt got %0d expected 3", stall_cnt); end
    checks++; if (pc !== 32'h400) begin errors++; $display("FAIL jr_pc_held got %h expected %h", pc, 32'h400); end
    tick();
    checks++; if (pc !== 32'h2000) begin errors++; $display("FAIL jr_target got %h expected %h", pc, 32'h2000); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL jr_flush got %b expected 1", flush); end
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL jr_no_link got %b expected 0", link_we); end
    settle();
  endtask
  task automatic test_jalr_misaligned;
    imem_ready = 1'b1;
    instr(OP_RTYPE, FN_JALR, 32'h500);
    rs_value = 32'h3002;
    #1;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL jalr_addr_err_pre got %b expected 0", addr_err); end
    tick();
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL jalr_target got %h expected %h", pc, 32'h3000); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL jalr_addr_err got %b expected 1", addr_err); end
    checks++; if (link_we !== 1'b1) begin errors++; $display("FAIL jalr_link_we got %b expected 1", link_we); end
    checks++; if (link_addr !== 32'h504) begin errors++; $display("FAIL jalr_link_addr got %h expected %h", link_addr, 32'h504); end
    rs_value = 32'h0;
    for (int i = 0; i < 10; i++) begin
      instr(6'h23, 6'h0, 32'h3000 + 32'(4 * i));
      tick();
      checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_sticky_%0d got %b expected 1", i, addr_err); end
    end
    instr_valid = 1'b0;
  endtask
  task automatic test_redirect_not_ready;
    imem_ready = 1'b0;
    instr(OP_J, 6'h0, 32'h1000);
    jidx = 26'h40;
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL j_not_ready_pc got %h expected %h", pc, 32'h100); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL j_not_ready_flush got %b expected 1", flush); end
    settle();
  endtask
  task automatic test_jr_cancel;
    imem_ready = 1'b1;
    instr(OP_RTYPE, FN_JALR, 32'h700);
    rs_hazard = 1'b1;
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL cancel_wait_stall got %b expected 1", stall); end
    instr_valid = 1'b0;
    imem_ready = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL cancel_stall got %b expected 0", stall); end
    tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL cancel_flush got %b expected 0", flush); end
    checks++; if (link_we !== 1'b0) begin errors++; $display("FAIL cancel_link got %b expected 0", link_we); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL cancel_pc got %h expected %h", pc, 32'h100); end
    imem_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL cancel_run_pc got %h expected %h", pc, 32'h104); end
  endtask
  task automatic test_reset_in_jr_wait;
    instr(OP_RTYPE, FN_JR, 32'h800);
    rs_hazard = 1'b1;
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstwait_stall got %b expected 1", stall); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rstwait_pc got %h expected 0", pc); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rstwait_pc_valid got %b expected 0", pc_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstwait_stall_clr got %b expected 0", stall); end
    checks++; if (stall_cnt !== 8'h0) begin errors++; $display("FAIL rstwait_stall_cnt got %0d expected 0", stall_cnt); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rstwait_addr_err got %b expected 0", addr_err); end
    checks++; if (link_addr !== 32'h0) begin errors++; $display("FAIL rstwait_link_addr got %h expected 0", link_addr); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rstwait_flush got %b expected 0", flush); end
  endtask
  initial begin
    test_reset();
    test_boot();
    test_branch();
    test_jal();
    test_jr_stall();
    test_jalr_misaligned();
    test_redirect_not_ready();
    test_jr_cancel();
    test_reset_in_jr_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
